imem_port_arbiter: RTL and testbench

- Shares the single read port of the instruction memory between two requesters: instruction fetch (IF, driven by the PC) and the syscall string reader (SR, walking string bytes word by word).
- Fixed priority to IF, with a starvation guard for SR.
- Enforces a one-cycle synchronous read handshake, range/alignment checking and a correct per-fetch instruction count.
- Sits between the fetch stage / syscall unit and the memory array.

---
 rtl/imem_arb_pkg.sv | 22 ++
 rtl/arb_wait_counter.sv | 36 +++
 rtl/imem_port_arbiter.sv | 113 +++++++++++
 tb/tb_imem_port_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// Shared types and helpers for the instruction-memory port arbiter.
// Holds the owner encoding, default memory geometry and the address range check.
package imem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_IF,
      OWN_SR
   } owner_t;

   localparam logic [31:0] DEF_MEM_BASE  = 32'h0040_0000;
   localparam int unsigned DEF_MEM_WORDS = 257;

   // 33-bit compare so a window ending at the top of the address space cannot wrap.
   function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base,
                                     input int unsigned words);
      logic [32:0] lim;
      lim = {1'b0, base} + (33'(words) << 2);
      return (addr[1:0] == 2'b00) && ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < lim);
   endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating starvation counter for the lower-priority requester.
// at_limit rises once the request has been denied MAX_WAIT cycles in a row.
module arb_wait_counter #(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic req,
   input  logic gnt,
   output logic at_limit
);

   localparam logic [3:0] Limit = 4'(MAX_WAIT);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!req || gnt) begin
         cnt_d = '0;
      end else if (cnt_q != Limit) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit = (cnt_q == Limit);

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the instruction-memory read port between instruction fetch (priority) and the
// syscall string reader, with a starvation override, range checking and a fetch counter.
module imem_port_arbiter
   import imem_arb_pkg::*;
#(
   parameter logic [31:0] MEM_BASE  = DEF_MEM_BASE,
   parameter int unsigned MEM_WORDS = DEF_MEM_WORDS,
   parameter int unsigned MAX_WAIT  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_valid,
   output logic [31:0] if_data,
   input  logic        sr_req,
   input  logic [31:0] sr_addr,
   output logic        sr_gnt,
   output logic        sr_valid,
   output logic [31:0] sr_data,
   output logic        mem_en,
   output logic [29:0] mem_waddr,
   input  logic [31:0] mem_rdata,
   output logic        err,
   output logic [31:0] fetch_count
);

   owner_t      owner_q, owner_d;
   logic        err_q, err_d;
   logic [31:0] fetch_count_q, fetch_count_d;
   logic [31:0] if_hold_q, if_hold_d;
   logic [31:0] sr_hold_q, sr_hold_d;
   logic        sr_at_limit;
   logic [31:0] gnt_addr, gnt_offset, rd_word;
   logic        gnt_any, gnt_ok;

   arb_wait_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_counter (
      .clk      (clk),
      .reset    (reset),
      .req      (sr_req),
      .gnt      (sr_gnt),
      .at_limit (sr_at_limit)
   );

   // Grants are held low while reset is asserted so nothing reaches the memory.
   always_comb begin
      if_gnt = 1'b0;
      sr_gnt = 1'b0;
      if (!reset) begin
         if (sr_req && (!if_req || sr_at_limit)) begin
            sr_gnt = 1'b1;
         end else if (if_req) begin
            if_gnt = 1'b1;
         end
      end
   end

   always_comb begin
      gnt_any    = if_gnt || sr_gnt;
      gnt_addr   = sr_gnt ? sr_addr : if_addr;
      gnt_ok     = in_range(gnt_addr, MEM_BASE, MEM_WORDS);
      gnt_offset = gnt_addr - MEM_BASE;
      mem_en     = gnt_any && gnt_ok;
      mem_waddr  = mem_en ? gnt_offset[31:2] : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_q       <= OWN_NONE;
         err_q         <= 1'b0;
         fetch_count_q <= '0;
         if_hold_q     <= '0;
         sr_hold_q     <= '0;
      end else begin
         owner_q       <= owner_d;
         err_q         <= err_d;
         fetch_count_q <= fetch_count_d;
         if_hold_q     <= if_hold_d;
         sr_hold_q     <= sr_hold_d;
      end
   end

   always_comb begin
      owner_d = OWN_NONE;
      if (sr_gnt) begin
         owner_d = OWN_SR;
      end else if (if_gnt) begin
         owner_d = OWN_IF;
      end
      err_d         = gnt_any && !gnt_ok;
      fetch_count_d = fetch_count_q;
      if (if_gnt && gnt_ok && (fetch_count_q != 32'hFFFF_FFFF)) begin
         fetch_count_d = fetch_count_q + 32'd1;
      end
   end

   // A rejected access still completes on schedule, delivering zero with err.
   always_comb begin
      rd_word     = err_q ? 32'h0 : mem_rdata;
      if_valid    = (owner_q == OWN_IF);
      sr_valid    = (owner_q == OWN_SR);
      err         = err_q;
      if_data     = if_valid ? rd_word : if_hold_q;
      sr_data     = sr_valid ? rd_word : sr_hold_q;
      if_hold_d   = if_data;
      sr_hold_d   = sr_data;
      fetch_count = fetch_count_q;
   end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed plus randomized bench for imem_port_arbiter against a cycle-level
// reference model built from the arbitration and access rules.
module tb_imem_port_arbiter;
   import imem_arb_pkg::*;

   localparam logic [31:0] BASE     = 32'h0040_0000;
   localparam int unsigned WORDS    = 257;
   localparam int unsigned MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, sr_req;
   logic [31:0] if_addr, sr_addr;
   logic        if_gnt, sr_gnt, if_valid, sr_valid, mem_en, err;
   logic [31:0] if_data, sr_data, mem_rdata, fetch_count;
   logic [29:0] mem_waddr;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int unsigned m_wait = 0;
   int          m_pend = 0;  // 0 none, 1 IF, 2 SR
   bit          m_perr = 1'b0;
   logic [31:0] m_if_hold = '0, m_sr_hold = '0, m_fc = '0;
   bit          m_if_g = 1'b0, m_sr_g = 1'b0;
   logic [31:0] fc_saved;

   imem_port_arbiter #(
      .MEM_BASE  (BASE),
      .MEM_WORDS (WORDS),
      .MAX_WAIT  (MAX_WAIT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .if_req      (if_req),
      .if_addr     (if_addr),
      .if_gnt      (if_gnt),
      .if_valid    (if_valid),
      .if_data     (if_data),
      .sr_req      (sr_req),
      .sr_addr     (sr_addr),
      .sr_gnt      (sr_gnt),
      .sr_valid    (sr_valid),
      .sr_data     (sr_data),
      .mem_en      (mem_en),
      .mem_waddr   (mem_waddr),
      .mem_rdata   (mem_rdata),
      .err         (err),
      .fetch_count (fetch_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_wait    = 0;
      m_pend    = 0;
      m_perr    = 1'b0;
      m_if_hold = '0;
      m_sr_hold = '0;
      m_fc      = '0;
      m_if_g    = 1'b0;
      m_sr_g    = 1'b0;
   endtask

   function automatic logic [31:0] pick_addr();
      case ($urandom_range(0, 3))
         0, 1:    return BASE + 4 * $urandom_range(0, WORDS - 1);
         2:       return BASE + $urandom_range(0, 4 * WORDS + 7);
         default: return $urandom;
      endcase
   endfunction

   // Called just after a falling edge with inputs applied; checks this cycle,
   // advances the model across the next rising edge, returns at the next falling edge.
   task automatic step();
      logic        e_if, e_sr, ok;
      logic [31:0] ga, dlv, exp_wa;
      longint      a;
      #1;
      e_sr = !reset && sr_req && (!if_req || m_wait == MAX_WAIT);
      e_if = !reset && if_req && !e_sr;
      ga   = e_sr ? sr_addr : if_addr;
      a    = longint'(ga);
      ok   = (e_if || e_sr) && (ga[1:0] == 2'b00) && (a >= longint'(BASE)) &&
             (a < longint'(BASE) + 4 * longint'(WORDS));
      exp_wa = ok ? 32'((a - longint'(BASE)) / 4) : 32'h0;
      dlv    = m_perr ? 32'h0 : mem_rdata;

      chkb("if_gnt", if_gnt, e_if);
      chkb("sr_gnt", sr_gnt, e_sr);
      chkb("mem_en", mem_en, ok);
      chk("mem_waddr", {2'b00, mem_waddr}, exp_wa);
      chkb("if_valid", if_valid, m_pend == 1);
      chkb("sr_valid", sr_valid, m_pend == 2);
      chkb("err", err, (m_pend != 0) && m_perr);
      chk("if_data", if_data, (m_pend == 1) ? dlv : m_if_hold);
      chk("sr_data", sr_data, (m_pend == 2) ? dlv : m_sr_hold);
      chk("fetch_count", fetch_count, m_fc);

      if (reset) begin
         model_reset();
      end else begin
         if (m_pend == 1) m_if_hold = dlv;
         if (m_pend == 2) m_sr_hold = dlv;
         m_pend = e_sr ? 2 : (e_if ? 1 : 0);
         m_perr = (e_if || e_sr) && !ok;
         if (e_if && ok && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
         if (!sr_req || e_sr) m_wait = 0;
         else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
         m_if_g = e_if;
         m_sr_g = e_sr;
      end
      @(negedge clk);
   endtask

   initial begin
      reset     = 1'b1;
      if_req    = 1'b1;
      sr_req    = 1'b1;
      if_addr   = BASE + 32'd16;
      sr_addr   = BASE + 32'd32;
      mem_rdata = 32'h0;
      @(negedge clk);
      step();
      step();

      // Release with both requesting: IF first, SR breaks through every fifth cycle.
      reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         mem_rdata = $urandom;
         #1;
         chkb("starve_sr_gnt", sr_gnt, (k % 5) == 4);
         chkb("starve_if_gnt", if_gnt, (k % 5) != 4);
         if (k == 1) begin
            chkb("first_if_valid", if_valid, 1'b1);
            chk("first_fetch_count", fetch_count, 32'd1);
         end
         step();
      end

      // Directed in-range IF read
      if_req  = 1'b1;
      if_addr = 32'h0040_0008;
      sr_req  = 1'b0;
      #1;
      chkb("if_rd_mem_en", mem_en, 1'b1);
      chk("if_rd_waddr", {2'b00, mem_waddr}, 32'd2);
      step();
      if_req    = 1'b0;
      mem_rdata = 32'h2402_000A;
      #1;
      chkb("if_rd_valid", if_valid, 1'b1);
      chk("if_rd_data", if_data, 32'h2402_000A);
      chkb("if_rd_err", err, 1'b0);
      step();

      // SR misaligned, then out of range
      for (int j = 0; j < 2; j++) begin
         fc_saved = m_fc;
         sr_req   = 1'b1;
         sr_addr  = (j == 0) ? 32'h0040_0402 : 32'h0050_0000;
         #1;
         chkb("sr_bad_mem_en", mem_en, 1'b0);
         chkb("sr_bad_gnt", sr_gnt, 1'b1);
         step();
         sr_req    = 1'b0;
         mem_rdata = $urandom | 32'h1;
         #1;
         chkb("sr_bad_valid", sr_valid, 1'b1);
         chkb("sr_bad_err", err, 1'b1);
         chk("sr_bad_data", sr_data, 32'h0);
         chk("sr_bad_fetch_count", fetch_count, fc_saved);
         step();
      end

      // Asynchronous reset in the cycle after an IF grant
      if_req  = 1'b1;
      if_addr = BASE + 32'd4;
      step();
      if_req = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chkb("arst_if_valid", if_valid, 1'b0);
      chk("arst_owner", 32'(dut.owner_q), 32'(OWN_NONE));
      chk("arst_fetch_count", fetch_count, 32'h0);
      model_reset();
      @(negedge clk);
      step();
      reset = 1'b0;
      #1;
      chkb("arst_no_late_valid", if_valid, 1'b0);
      step();

      // Saturation of the fetch counter
      force dut.fetch_count_q = 32'hFFFF_FFFE;
      #1;
      release dut.fetch_count_q;
      m_fc = 32'hFFFF_FFFE;
      step();
      for (int i = 0; i < 3; i++) begin
         if_req  = 1'b1;
         if_addr = BASE + 4 * i;
         step();
      end
      if_req = 1'b0;
      step();
      #1;
      chk("sat_fetch_count", fetch_count, 32'hFFFF_FFFF);
      @(negedge clk);

      // Randomized traffic, honouring the hold-until-grant rule
      for (int n = 0; n < 400; n++) begin
         if (!(if_req && !m_if_g)) begin
            if_req  = ($urandom % 4) != 0;
            if_addr = pick_addr();
         end
         if (sr_req && !m_sr_g) begin
            if (($urandom % 8) == 0) sr_req = 1'b0;
         end else begin
            sr_req  = ($urandom % 3) == 0;
            sr_addr = pick_addr();
         end
         mem_rdata = $urandom;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
